oeo_buf_requester: RTL and testbench
====================================

// Module: oeo_buf_requester
// PURPOSE
//  Requester side of the OEO recirculation buffer for one switch port (instantiated PORTS times).
//  - Stores packets that lost speculative arbitration and were recirculated into the buffer.
//  - Issues one req_buf request per stored packet to the recirculation allocator.
//  - On grant_buf, replays the head packet towards the photonic switch during the granted slot.
// PARAMETERS
//  PORTS       4   number of switch ports; request port field width is log2(PORTS)
//  SLOT_SIZE   4   words per packet (= one switch slot), >=2
//  FIFO_DEPTH  4   packets held in the buffer, >=1
//  DATA_WIDTH  32  width of one packet word
// PORTS
//  clk          in   1                 clock; all logic on rising edge
//  rst          in   1                 synchronous reset, active-low
//  in_valid     in   1                 recirculated word valid
//  in_sop       in   1                 first word of packet (qualified by in_valid)
//  in_dest      in   log2(PORTS)       destination port, sampled on sop
//  in_data      in   DATA_WIDTH        packet word
//  req_valid    out  1                 req_buf.valid to allocator
//  req_port     out  log2(PORTS)       req_buf.port to allocator
//  grant_valid  in   1                 grant_buf.valid from allocator
//  out_valid    out  1                 replayed word valid
//  out_sop      out  1                 first replayed word
//  out_dest     out  log2(PORTS)       destination of replayed packet
//  out_data     out  DATA_WIDTH        replayed word
//  occupancy    out  log2(FIFO_DEPTH)+1  committed packets stored
//  drop_count   out  16                dropped/aborted packets, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst==0 at edge): all outputs 0; FSM=IDLE; FIFO emptied; partial packets discarded.
//  Write side: a packet is SLOT_SIZE contiguous in_valid words, the first with in_sop.
//  - Full check at sop only: if occupancy==FIFO_DEPTH, drop the whole packet; drop_count++.
//    A pop later in that packet does not rescue it.
//  - A gap (in_valid=0) mid-packet aborts the packet; drop_count++.
//  - A new sop mid-packet aborts the old packet (drop_count++) and starts the new one.
//  - Words without sop while not assembling are ignored.
//  - Commit on the last word: occupancy increments the following cycle.
//  Read FSM (head = oldest committed packet):
//  - IDLE: if occupancy>0, go to REQ.
//  - REQ: req_valid=1 for exactly one cycle, req_port=head dest; then go to WAIT.
//    Exactly one request is issued per packet; the allocator counts requests.
//  - WAIT: req_valid=0; hold indefinitely until grant_valid=1, then go to SEND.
//  - SEND: starts the cycle after the grant is sampled. Outputs SLOT_SIZE words on consecutive cycles:
//    out_valid=1; out_sop on word 0; out_dest=head dest.
//    The head is popped on the last word. Next state is REQ if occupancy after the pop >0, else IDLE.
//  - grant_valid outside WAIT is ignored (no effect, no count).
//  - Latency from first word in to req_valid, with an empty buffer: SLOT_SIZE+2 cycles
//    (commit, then IDLE->REQ).
//  - Commit and pop in the same cycle leave occupancy unchanged.
//  - Storage wraps modulo FIFO_DEPTH for both pointers.
//  - Reset mid-SEND: out_valid drops to 0 the next cycle; the packet is lost.
// TESTING (PORTS=4, SLOT_SIZE=4, FIFO_DEPTH=2, DATA_WIDTH=32)
//  1. Packet dest=2, words A0..A3 into empty buffer -> single-cycle req_valid with req_port=2,
//     6 cycles after A0; grant 3 cycles later -> A0..A3 out on next 4 cycles, out_sop on A0,
//     occupancy 1->0.
//  2. Three back-to-back packets, no grants -> third dropped, drop_count=1, occupancy=2,
//     only one req pulse (head).
//  3. Two packets (dest 1, then 3), grants after each request -> req_port 1 then 3;
//     second req in the cycle after the first packet's last word; data order preserved.
//  4. Gap after word 2 of a packet -> drop_count=1, occupancy stays 0, no req_valid.
//  5. grant_valid pulsed while IDLE and during SEND -> no extra output, no state change.
//  6. rst=0 during SEND word 1 -> next cycle all outputs 0, occupancy=0;
//     a new packet afterwards follows scenario 1 timing.

Source files
------------

// File: rtl/oeo_buf_requester.sv
// oeo_buf_requester: recirculation buffer requester for one switch port
// Stores packets that lost speculative arbitration, issues one allocator
// request per stored packet, and replays the head packet when granted.
// Ports:
//   clk_i, rst_i           clock, synchronous active-low reset
//   in_valid_i/in_sop_i    recirculated word valid / first word of packet
//   in_dest_i, in_data_i   destination port (sampled on sop), packet word
//   req_valid_o/req_port_o one-cycle buffer request and its destination
//   grant_valid_i          buffer grant from the allocator
//   out_valid_o/out_sop_o  replayed word valid / first replayed word
//   out_dest_o/out_data_o  replayed packet destination and word
//   occupancy_o            committed packets stored
//   drop_count_o           dropped or aborted packets, saturating
module oeo_buf_requester #(
  parameter int PORTS = 4,
  parameter int SLOT_SIZE = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1,
  localparam int OW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic                  in_sop_i,
  input  logic [PW-1:0]         in_dest_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  req_valid_o,
  output logic [PW-1:0]         req_port_o,
  input  logic                  grant_valid_i,
  output logic                  out_valid_o,
  output logic                  out_sop_o,
  output logic [PW-1:0]         out_dest_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [OW-1:0]         occupancy_o,
  output logic [15:0]           drop_count_o
);
  localparam int SW = $clog2(SLOT_SIZE);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [SW-1:0] LAST = SW'(SLOT_SIZE - 1);
  localparam logic [AW-1:0] PMAX = AW'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SEND} state_t;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH][SLOT_SIZE];
  logic [PW-1:0] dst_q [FIFO_DEPTH];
  state_t state_q, state_d;
  logic act_q, act_d, disc_q, disc_d, commit_q, commit_d, we, pop, full;
  logic [SW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, wa;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [1:0] inc;
  logic [16:0] sum;
  logic [15:0] drop_q, drop_d;
  // act: storing a packet; disc: swallowing the rest of a packet dropped as full.
  // The committing packet is counted in the full check before occupancy shows it.
  always_comb begin
    act_d = act_q;
    disc_d = disc_q;
    wcnt_d = wcnt_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = 1'b0;
    we = 1'b0;
    inc = 2'd0;
    full = (occ_q + OW'(commit_q)) >= OW'(FIFO_DEPTH);
    if (in_valid_i && in_sop_i) begin
      inc = {1'b0, act_q} + {1'b0, full};
      act_d = !full;
      disc_d = full;
      wcnt_d = SW'(1);
      we = !full;
    end else if (in_valid_i) begin
      if (act_q || disc_q) begin
        we = act_q;
        wcnt_d = wcnt_q == LAST ? '0 : wcnt_q + SW'(1);
        if (wcnt_q == LAST) begin
          act_d = 1'b0;
          disc_d = 1'b0;
          commit_d = act_q;
          wr_ptr_d = act_q ? (wr_ptr_q == PMAX ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
        end
      end
    end else begin
      inc = {1'b0, act_q};
      act_d = 1'b0;
      disc_d = 1'b0;
    end
    wa = in_sop_i ? '0 : wcnt_q;
    sum = {1'b0, drop_q} + 17'(inc);
    drop_d = sum[16] ? 16'hFFFF : sum[15:0];
  end
  always_comb begin
    state_d = state_q;
    rcnt_d = rcnt_q;
    rd_ptr_d = rd_ptr_q;
    pop = state_q == S_SEND && rcnt_q == LAST;
    occ_d = occ_q + OW'(commit_q) - OW'(pop);
    case (state_q)
      S_IDLE: state_d = occ_q != '0 ? S_REQ : S_IDLE;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        state_d = grant_valid_i ? S_SEND : S_WAIT;
        rcnt_d = '0;
      end
      default: begin
        rcnt_d = pop ? '0 : rcnt_q + SW'(1);
        rd_ptr_d = pop ? (rd_ptr_q == PMAX ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
        state_d = !pop ? S_SEND : occ_d != '0 ? S_REQ : S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      act_q <= 1'b0;
      disc_q <= 1'b0;
      commit_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      disc_q <= disc_d;
      commit_q <= commit_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q <= occ_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i && we) mem_q[wr_ptr_q][wa] <= in_data_i;
    if (rst_i && we && in_sop_i) dst_q[wr_ptr_q] <= in_dest_i;
  end
  assign req_valid_o = state_q == S_REQ;
  assign req_port_o = state_q == S_REQ ? dst_q[rd_ptr_q] : '0;
  assign out_valid_o = state_q == S_SEND;
  assign out_sop_o = state_q == S_SEND && rcnt_q == '0;
  assign out_dest_o = state_q == S_SEND ? dst_q[rd_ptr_q] : '0;
  assign out_data_o = state_q == S_SEND ? mem_q[rd_ptr_q][rcnt_q] : '0;
  assign occupancy_o = occ_q;
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_oeo_buf_requester.sv
// tb_oeo_buf_requester: directed scenarios for the recirculation buffer requester
module tb_oeo_buf_requester;
  logic clk = 0, rst = 0, in_valid = 0, in_sop = 0, grant = 0;
  logic [1:0] in_dest = 0;
  logic [31:0] in_data = 0;
  logic req_valid, out_valid, out_sop;
  logic [1:0] req_port, out_dest, occupancy;
  logic [31:0] out_data;
  logic [15:0] drop_count;
  int n_chk = 0, n_fail = 0, req_cnt = 0;
  logic [1:0] req_port_seen = 0;
  oeo_buf_requester #(.PORTS(4), .SLOT_SIZE(4), .FIFO_DEPTH(2), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_sop_i(in_sop),
    .in_dest_i(in_dest), .in_data_i(in_data), .req_valid_o(req_valid),
    .req_port_o(req_port), .grant_valid_i(grant), .out_valid_o(out_valid),
    .out_sop_o(out_sop), .out_dest_o(out_dest), .out_data_o(out_data),
    .occupancy_o(occupancy), .drop_count_o(drop_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (req_valid === 1'b1) begin
    req_cnt++;
    req_port_seen = req_port;
  end
  task tick;
    @(posedge clk);
    #1;
  endtask
  task drive(input logic v, input logic s, input logic [1:0] d, input logic [31:0] x);
    in_valid = v;
    in_sop = s;
    in_dest = d;
    in_data = x;
  endtask
  task do_reset;
    rst = 0;
    grant = 0;
    drive(0, 0, 0, 0);
    tick;
    rst = 1;
  endtask
  task push_pkt(input logic [1:0] d, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, d, base + i);
      tick;
    end
    drive(0, 0, 0, 0);
  endtask
  task test_reset;
    rst = 0;
    grant = 1;
    drive(1, 1, 3, 32'hFFFF_FFFF);
    tick;
    tick;
    n_chk++;
    if ({req_valid, req_port, out_valid, out_sop, out_dest, out_data, occupancy, drop_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b rp=%0d ov=%b os=%b od=%0d data=%h occ=%0d drop=%0d want all 0",
               req_valid, req_port, out_valid, out_sop, out_dest, out_data, occupancy, drop_count);
    end
    rst = 1;
    grant = 0;
    drive(0, 0, 0, 0);
  endtask
  task test_single;
    logic [35:0] exp;
    int r0;
    do_reset;
    r0 = req_cnt;
    push_pkt(2, 32'hA0);
    tick;
    n_chk++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL s1_req_early: got %b want 0", req_valid); end
    n_chk++;
    if (occupancy !== 2'd1) begin n_fail++; $display("FAIL s1_occ_commit: got %0d want 1", occupancy); end
    tick;
    n_chk++;
    if ({req_valid, req_port} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL s1_req: got v=%b p=%0d want v=1 p=2", req_valid, req_port); end
    tick;
    n_chk++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL s1_req_single: got %b want 0", req_valid); end
    tick;
    tick;
    grant = 1;
    tick;
    grant = 0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, i == 0, 2'd2, 32'hA0 + i};
      n_chk++;
      if ({out_valid, out_sop, out_dest, out_data} !== exp) begin
        n_fail++;
        $display("FAIL s1_word%0d: got %h want %h", i, {out_valid, out_sop, out_dest, out_data}, exp);
      end
      tick;
    end
    n_chk++;
    if ({out_valid, occupancy} !== 3'b000) begin n_fail++; $display("FAIL s1_after: got ov=%b occ=%0d want 0 0", out_valid, occupancy); end
    tick;
    n_chk++;
    if (req_cnt - r0 !== 1) begin n_fail++; $display("FAIL s1_req_count: got %0d want 1", req_cnt - r0); end
  endtask
  task test_overflow;
    int r0;
    do_reset;
    r0 = req_cnt;
    for (int p = 0; p < 3; p++) push_pkt(2'(p + 1), 32'h100 * (p + 1));
    repeat (6) tick;
    n_chk++;
    if (drop_count !== 16'd1) begin n_fail++; $display("FAIL s2_drop: got %0d want 1", drop_count); end
    n_chk++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL s2_occ: got %0d want 2", occupancy); end
    n_chk++;
    if (req_cnt - r0 !== 1 || req_port_seen !== 2'd1) begin
      n_fail++;
      $display("FAIL s2_req: got count=%0d port=%0d want count=1 port=1", req_cnt - r0, req_port_seen);
    end
  endtask
  task test_back_to_back;
    logic [35:0] exp;
    int r0;
    do_reset;
    r0 = req_cnt;
    push_pkt(1, 32'h10);
    push_pkt(3, 32'h20);
    n_chk++;
    if (req_cnt - r0 !== 1 || req_port_seen !== 2'd1) begin
      n_fail++;
      $display("FAIL s3_req1: got count=%0d port=%0d want count=1 port=1", req_cnt - r0, req_port_seen);
    end
    grant = 1;
    tick;
    grant = 0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, i == 0, 2'd1, 32'h10 + i};
      n_chk++;
      if ({out_valid, out_sop, out_dest, out_data} !== exp) begin
        n_fail++;
        $display("FAIL s3_p1_word%0d: got %h want %h", i, {out_valid, out_sop, out_dest, out_data}, exp);
      end
      tick;
    end
    n_chk++;
    if ({req_valid, req_port} !== {1'b1, 2'd3}) begin n_fail++; $display("FAIL s3_req2: got v=%b p=%0d want v=1 p=3", req_valid, req_port); end
    tick;
    grant = 1;
    tick;
    grant = 0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, i == 0, 2'd3, 32'h20 + i};
      n_chk++;
      if ({out_valid, out_sop, out_dest, out_data} !== exp) begin
        n_fail++;
        $display("FAIL s3_p2_word%0d: got %h want %h", i, {out_valid, out_sop, out_dest, out_data}, exp);
      end
      tick;
    end
    n_chk++;
    if ({out_valid, occupancy} !== 3'b000 || req_cnt - r0 !== 2) begin
      n_fail++;
      $display("FAIL s3_after: got ov=%b occ=%0d reqs=%0d want 0 0 2", out_valid, occupancy, req_cnt - r0);
    end
  endtask
  task test_gap;
    int r0;
    do_reset;
    r0 = req_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, 2, 32'hB0 + i);
      tick;
    end
    drive(0, 0, 0, 0);
    repeat (8) tick;
    n_chk++;
    if (drop_count !== 16'd1) begin n_fail++; $display("FAIL s4_drop: got %0d want 1", drop_count); end
    n_chk++;
    if (occupancy !== 2'd0 || req_cnt - r0 !== 0) begin
      n_fail++;
      $display("FAIL s4_no_store: got occ=%0d reqs=%0d want 0 0", occupancy, req_cnt - r0);
    end
  endtask
  task test_grant_ignore;
    logic [35:0] exp;
    int r0;
    do_reset;
    r0 = req_cnt;
    grant = 1;
    repeat (3) tick;
    n_chk++;
    if ({out_valid, req_valid, occupancy} !== 4'b0000 || req_cnt - r0 !== 0) begin
      n_fail++;
      $display("FAIL s5_idle_grant: got ov=%b rv=%b occ=%0d reqs=%0d want 0", out_valid, req_valid, occupancy, req_cnt - r0);
    end
    push_pkt(0, 32'hC0);
    tick;
    grant = 0;
    tick;
    n_chk++;
    if ({req_valid, req_port} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL s5_req: got v=%b p=%0d want v=1 p=0", req_valid, req_port); end
    tick;
    grant = 1;
    tick;
    grant = 0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, i == 0, 2'd0, 32'hC0 + i};
      n_chk++;
      if ({out_valid, out_sop, out_dest, out_data} !== exp) begin
        n_fail++;
        $display("FAIL s5_word%0d: got %h want %h", i, {out_valid, out_sop, out_dest, out_data}, exp);
      end
      grant = i == 1;
      tick;
    end
    grant = 0;
    repeat (4) tick;
    n_chk++;
    if ({out_valid, occupancy} !== 3'b000 || req_cnt - r0 !== 1 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL s5_after: got ov=%b occ=%0d reqs=%0d drop=%0d want 0 0 1 0", out_valid, occupancy, req_cnt - r0, drop_count);
    end
  endtask
  task test_reset_send;
    int r0;
    do_reset;
    push_pkt(1, 32'hD0);
    repeat (3) tick;
    grant = 1;
    tick;
    grant = 0;
    tick;
    n_chk++;
    if ({out_valid, out_sop, out_data} !== {1'b1, 1'b0, 32'hD1}) begin
      n_fail++;
      $display("FAIL s6_word1: got ov=%b os=%b data=%h want 1 0 d1", out_valid, out_sop, out_data);
    end
    rst = 0;
    tick;
    n_chk++;
    if ({req_valid, req_port, out_valid, out_sop, out_dest, out_data, occupancy, drop_count} !== '0) begin
      n_fail++;
      $display("FAIL s6_reset: got ov=%b data=%h occ=%0d want all 0", out_valid, out_data, occupancy);
    end
    rst = 1;
    r0 = req_cnt;
    push_pkt(2, 32'hE0);
    tick;
    n_chk++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL s6_req_early: got %b want 0", req_valid); end
    tick;
    n_chk++;
    if ({req_valid, req_port} !== {1'b1, 2'd2} || req_cnt - r0 !== 0) begin
      n_fail++;
      $display("FAIL s6_req: got v=%b p=%0d prior=%0d want v=1 p=2 prior=0", req_valid, req_port, req_cnt - r0);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_back_to_back;
    test_gap;
    test_grant_ignore;
    test_reset_send;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
